// File: rtl/pwm_multi_gen_if.sv
// Bus bundle between the register/config block and pwm_multi_gen: run control,
// double-buffered period/duty load, and the PWM outputs toward the pads.
interface pwm_multi_gen_if #(
    parameter int CH = 4,
    parameter int CW = 8,
    parameter int PW = 8
);
    logic              i_en;
    logic [PW-1:0]     i_presc;
    logic [CW-1:0]     i_period;
    logic [CH*CW-1:0]  i_duty;
    logic              i_load;
    logic              i_center;
    logic [CH-1:0]     o_pwm;
    logic              o_period_end;
    logic              o_load_pend;

    modport master (
        output i_en, i_presc, i_period, i_duty, i_load, i_center,
        input  o_pwm, o_period_end, o_load_pend
    );

    modport slave (
        input  i_en, i_presc, i_period, i_duty, i_load, i_center,
        output o_pwm, o_period_end, o_load_pend
    );
endinterface

// File: rtl/pwm_multi_gen.sv
// Multi-channel PWM generator: shared prescaled period counter, per-channel duty
// compare, shadow registers applied at period boundaries. Macro PWM_CENTER_EN adds center-aligned mode.
module pwm_multi_gen #(
    parameter int CH = 4,
    parameter int CW = 8,
    parameter int PW = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    pwm_multi_gen_if.slave    bus
);
    logic [PW-1:0] presc_reg, presc_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [CW-1:0] per_act_reg, per_sh_reg;
    logic          pend_reg, pe_reg;
    logic [CH-1:0] pwm_reg, pwm_next;
    logic          tick, boundary, apply;

    // Lowering i_presc below the count lets it run on and wrap at all-ones.
    always_comb begin
        tick       = bus.i_en && (presc_reg == bus.i_presc);
        presc_next = presc_reg + PW'(1);
        if (!bus.i_en || tick) begin
            presc_next = '0;
        end
    end

`ifdef PWM_CENTER_EN
    logic center_reg, center_next;
    logic dir_up_reg, dir_up_next;

    always_comb begin
        cnt_next    = cnt_reg;
        boundary    = 1'b0;
        dir_up_next = dir_up_reg;
        center_next = center_reg;
        if (!bus.i_en) begin
            cnt_next    = '0;
            dir_up_next = 1'b1;
            center_next = bus.i_center;
        end else if (tick) begin
            if (!center_reg) begin
                if (cnt_reg == per_act_reg) begin
                    cnt_next = '0;
                    boundary = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end else if (dir_up_reg) begin
                if (cnt_reg == per_act_reg) begin
                    // With P of 0 or 1 the turnaround lands directly on 0.
                    if (per_act_reg <= CW'(1)) begin
                        cnt_next = '0;
                        boundary = 1'b1;
                    end else begin
                        cnt_next    = cnt_reg - CW'(1);
                        dir_up_next = 1'b0;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end else begin
                cnt_next = cnt_reg - CW'(1);
                if (cnt_reg <= CW'(1)) begin
                    cnt_next    = '0;
                    boundary    = 1'b1;
                    dir_up_next = 1'b1;
                end
            end
            if (boundary) begin
                center_next = bus.i_center;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            center_reg <= 1'b0;
            dir_up_reg <= 1'b1;
        end else begin
            center_reg <= center_next;
            dir_up_reg <= dir_up_next;
        end
    end
`else
    always_comb begin
        cnt_next = cnt_reg;
        boundary = 1'b0;
        if (!bus.i_en) begin
            cnt_next = '0;
        end else if (tick) begin
            if (cnt_reg == per_act_reg) begin
                cnt_next = '0;
                boundary = 1'b1;
            end else begin
                cnt_next = cnt_reg + CW'(1);
            end
        end
    end
`endif

    // Disabled: no period to protect, so pending values go live immediately.
    assign apply = (boundary || !bus.i_en) && pend_reg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc_reg   <= '0;
            cnt_reg     <= '0;
            per_act_reg <= '1;
            per_sh_reg  <= '1;
            pend_reg    <= 1'b0;
            pe_reg      <= 1'b0;
            pwm_reg     <= '0;
        end else begin
            presc_reg <= presc_next;
            cnt_reg   <= cnt_next;
            pe_reg    <= boundary;
            pwm_reg   <= pwm_next;
            if (apply) begin
                per_act_reg <= per_sh_reg;
            end
            if (bus.i_load) begin
                per_sh_reg <= bus.i_period;
                pend_reg   <= 1'b1;
            end else if (apply) begin
                pend_reg <= 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            logic [CW-1:0] duty_act_reg, duty_sh_reg;

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    duty_act_reg <= '0;
                    duty_sh_reg  <= '0;
                end else begin
                    if (apply) begin
                        duty_act_reg <= duty_sh_reg;
                    end
                    if (bus.i_load) begin
                        duty_sh_reg <= bus.i_duty[gi*CW +: CW];
                    end
                end
            end

            assign pwm_next[gi] = bus.i_en && (cnt_reg < duty_act_reg);
        end
    endgenerate

    assign bus.o_pwm        = pwm_reg;
    assign bus.o_period_end = pe_reg;
    assign bus.o_load_pend  = pend_reg;
endmodule

// File: tb/tb_pwm_multi_gen.sv
// Randomized scoreboard bench for pwm_multi_gen: a period-position reference model
// predicts every clock's outputs; a monitor compares them after each edge.
module tb_pwm_multi_gen;
    localparam int CH = 4;
    localparam int CW = 8;
    localparam int PW = 8;
    localparam int MAXV = (1 << CW) - 1;

    typedef struct {
        logic [CH-1:0] pwm;
        logic          pe;
        logic          pend;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pwm_multi_gen_if #(.CH(CH), .CW(CW), .PW(PW)) bus ();

    pwm_multi_gen #(.CH(CH), .CW(CW), .PW(PW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    // Stimulus state applied on each step.
    bit               cur_rst, cur_en, cur_load, cur_center;
    int               cur_presc, cur_per;
    logic [CH*CW-1:0] cur_duty;

    // Reference model: position within the current period (in ticks and clocks).
    int m_q, m_k, m_P, m_sP;
    int m_D[CH];
    int m_sD[CH];
    bit m_pend, m_center;

    task automatic model_step(output exp_t e);
        int  len, cnt;
        bit  tick, bnd, apply;
        e.cyc = cyc;
        if (cur_rst) begin
            m_q = 0; m_k = 0; m_P = MAXV; m_sP = MAXV;
            m_pend = 0; m_center = 0;
            for (int c = 0; c < CH; c++) begin
                m_D[c] = 0; m_sD[c] = 0;
            end
            e.pwm = '0; e.pe = 1'b0; e.pend = 1'b0;
            return;
        end
        // Edge mode: ticks 0..P. Center mode: up to P and back, 2P ticks total.
        len = m_center ? ((m_P == 0) ? 1 : 2 * m_P) : m_P + 1;
        cnt = (m_center && m_k > m_P) ? 2 * m_P - m_k : m_k;
        for (int c = 0; c < CH; c++) begin
            e.pwm[c] = cur_en && (cnt < m_D[c]);
        end
        tick  = cur_en && (m_q == cur_presc);
        bnd   = tick && (m_k == len - 1);
        apply = (bnd || !cur_en) && m_pend;
        e.pe   = bnd;
        e.pend = cur_load ? 1'b1 : (apply ? 1'b0 : m_pend);

        if (!cur_en) begin
            m_q = 0; m_k = 0;
        end else if (tick) begin
            m_q = 0;
            m_k = bnd ? 0 : m_k + 1;
        end else begin
            m_q = m_q + 1;
        end
`ifdef PWM_CENTER_EN
        if (bnd || !cur_en) m_center = cur_center;
`endif
        if (apply) begin
            m_P = m_sP;
            for (int c = 0; c < CH; c++) m_D[c] = m_sD[c];
        end
        if (cur_load) begin
            m_sP = cur_per;
            for (int c = 0; c < CH; c++) m_sD[c] = int'(cur_duty[c*CW +: CW]);
        end
        m_pend = e.pend;
    endtask

    task automatic step();
        exp_t e;
        @(negedge clk);
        rst          = cur_rst;
        bus.i_en     = cur_en;
        bus.i_load   = cur_load;
        bus.i_center = cur_center;
        bus.i_presc  = PW'(cur_presc);
        bus.i_period = CW'(cur_per);
        bus.i_duty   = cur_duty;
        model_step(e);
        sb_q.push_back(e);
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input int per, input int d0, input int d1, input int d2, input int d3);
        cur_per = per;
        cur_duty = {CW'(d3), CW'(d2), CW'(d1), CW'(d0)};
        cur_load = 1'b1;
        step();
        cur_load = 1'b0;
    endtask

    // Monitor: compares the DUT against the oldest prediction just after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_tests++;
            if (bus.o_pwm !== e.pwm) begin
                n_fail++;
                $display("FAIL pwm cyc=%0d got=%b exp=%b", e.cyc, bus.o_pwm, e.pwm);
            end
            n_tests++;
            if (bus.o_period_end !== e.pe) begin
                n_fail++;
                $display("FAIL period_end cyc=%0d got=%b exp=%b", e.cyc, bus.o_period_end, e.pe);
            end
            n_tests++;
            if (bus.o_load_pend !== e.pend) begin
                n_fail++;
                $display("FAIL load_pend cyc=%0d got=%b exp=%b", e.cyc, bus.o_load_pend, e.pend);
            end
        end
    end

    initial begin
        int p;
        cur_rst = 1; cur_en = 0; cur_load = 0; cur_center = 0;
        cur_presc = 0; cur_per = 0; cur_duty = '0;
        run(3);
        cur_rst = 0; cur_en = 1;
        run(5);

        // Basic 4-channel pattern, period 10.
        do_load(9, 3, 0, 10, 5);
        run(40);
        // Prescaled: period 20 clocks.
        cur_en = 0; cur_presc = 3; step();
        cur_en = 1;
        do_load(4, 2, 1, 5, 0);
        run(50);
        cur_en = 0; cur_presc = 0; step();
        cur_en = 1;
        do_load(9, 3, 0, 10, 5);
        run(13);
        // Mid-period reload, then two loads in one period.
        do_load(4, 4, 2, 0, 5);
        run(15);
        do_load(9, 1, 1, 1, 1);
        do_load(9, 7, 2, 3, 9);
        run(25);
        // Disable mid-period, load while disabled, re-enable.
        cur_en = 0; run(2);
        do_load(6, 2, 3, 7, 0);
        run(2);
        cur_en = 1; run(20);
        // Reset while a load is pending.
        do_load(3, 1, 1, 1, 1);
        cur_rst = 1; step(); cur_rst = 0;
        run(20);
        do_load(5, 2, 4, 6, 1);
        run(15);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                cur_en = !cur_en;
                if (!cur_en) cur_presc = $urandom_range(0, 3);
            end
            cur_center = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 99) < 6) begin
                p = ($urandom_range(0, 19) == 0) ? MAXV : $urandom_range(0, 12);
                cur_per = p;
                for (int c = 0; c < CH; c++) begin
                    cur_duty[c*CW +: CW] = CW'((p + 2 > MAXV) ? $urandom_range(0, MAXV)
                                                              : $urandom_range(0, p + 2));
                end
                cur_load = 1'b1;
            end
            step();
            cur_load = 1'b0;
        end

        @(posedge clk);
        #2;
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d exp=0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pwm_multi_gen.md
Name: pwm_multi_gen

Overview:
- Multi-channel PWM generator; next generation of the single-channel fixed-table generator.
- CH channels share one programmable period counter with a programmable clock prescaler.
- Per-channel duty is set in counter ticks. Period and duty updates are double-buffered and applied only at a period boundary, so outputs never glitch.
- Sits between the register/config logic and the pad drivers (motor/LED/servo outputs).

Parameters:
- CH, 4, number of PWM channels (1..16)
- CW, 8, counter, period and duty width in bits (4..16)
- PW, 8, prescaler width in bits

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_en  in  1  run enable; low = counter held, all outputs low
- i_presc  in  PW  prescaler; one counter tick every i_presc+1 clocks; sampled live
- i_period  in  CW  period value P; captured on i_load
- i_duty  in  CH*CW  packed duties; channel c = bits [c*CW +: CW]; captured on i_load
- i_load  in  1  one-clock strobe; capture i_period/i_duty into shadow registers
- i_center  in  1  center-aligned mode select (see Optional Feature); sampled at period boundary
- o_pwm  out  CH  PWM outputs, registered
- o_period_end  out  1  one-clock pulse on each period-boundary tick
- o_load_pend  out  1  shadow holds values not yet applied

Behaviour:
- Reset (i_rst=1 at clock edge) values:
  - prescaler count = 0, counter = 0
  - active period = all-ones
  - active and shadow duties = 0
  - o_pwm = 0, o_period_end = 0, o_load_pend = 0
- Reset mid-period discards pending shadow values.
- Prescaler:
  - Counts 0..i_presc; a tick is asserted on the clock where count == i_presc, then the count returns to 0.
  - i_presc=0 gives a tick every clock.
  - If i_presc is lowered below the current count, the count wraps at its all-ones value. This is legal, not an error.
- Edge-aligned counter: on a tick, if cnt == P_act then cnt <= 0 and this is a boundary tick; otherwise cnt <= cnt+1.
  - Period = (P_act+1)*(i_presc+1) clocks.
  - P_act=0 gives every tick a boundary.
- Output:
  - o_pwm[c] <= i_en & (cnt < D_act[c]), using unsigned CW-bit compare.
  - One clock of latency after the counter value.
  - D=0: constant low. D >= P_act+1: constant high (100%). No clamping logic beyond the compare.
- o_period_end: registered pulse, high for the clock following a boundary tick.
- Load handshake:
  - i_load=1: shadow <= i_period/i_duty, and o_load_pend <= 1 on the next clock.
  - On a boundary tick with pend=1: active <= shadow and pend <= 0. The new values govern the period starting at cnt=0.
  - i_load while pend=1: shadow is overwritten (last write wins); pend stays 1.
  - i_load on the same clock as an applying boundary tick: the old shadow is applied and the new values are captured; pend remains 1 for the next boundary.
  - i_en=0: pending shadow is applied on the next clock (no boundary wait), and pend clears.
- Enable:
  - i_en low: prescaler count and cnt are forced to 0, direction is set to up, o_pwm goes to 0 the next clock, and no o_period_end pulses occur.
  - i_en rising: a fresh period starts at cnt=0.

Optional Feature:
- Macro: PWM_CENTER_EN.
- Defined: when i_center=1 (latched at boundary or while disabled), the counter runs up/down: 0,1..P_act,P_act-1..1, then 0 again.
  - Boundary = the tick returning to 0. Period = 2*P_act ticks; P_act=0 gives a 1-tick period.
  - Compare is unchanged, so each pulse is symmetric about cnt=0.
  - High ticks per period = 2D-1 for 1 <= D <= P_act; 0 for D=0; all ticks for D >= P_act+1.
- Not defined: i_center is ignored, there is no direction register, and behaviour is edge-aligned only.

Test Plan:
- Reset, i_en=1, i_presc=0, load P=9, D0=3, D1=0, D2=10, D3=5 -> after the first boundary:
  - ch0 high 3 of every 10 clocks, ch1 constant 0, ch2 constant 1, ch3 5 of 10
  - o_period_end every 10 clocks
- i_presc=3, P=4, D0=2 -> period 20 clocks, ch0 high 8 clocks; o_period_end pulse is 1 clock wide.
- Mid-period i_load P=4,D0=4 while running P=9,D0=3 -> o_load_pend=1 until the boundary; the current period completes as 3/10, then becomes 4/5. No runt pulse.
- Two i_load strobes within one period (D0=1 then D0=7) -> only D0=7 is applied. A third load on the boundary clock stays pending one more period.
- Drop i_en mid-period -> o_pwm=0 next clock and counter at 0. Load while disabled -> pend clears next clock. Re-enable -> cnt starts at 0.
- With PWM_CENTER_EN, i_center=1, P=4, D0=2 -> ch0 sequence over cnt 0,1,2,3,4,3,2,1 is 1,1,0,0,0,0,0,1, giving period 8.
